ksa_swap_fsm: RTL and testbench
===============================

# ksa_swap_fsm

RC4 key-scheduling stage. Runs the 256-iteration swap loop over the on-chip S-memory, `j = j + S[i] + key[i mod KEY_BYTES]`, then swaps S[i] and S[j]. It starts only after the S-memory initialization stage has written S[i]=i and raised its completion flag, which the top level routes to `start`. It drives the shared single-port S-memory through its own address, data and wren outputs. The top level muxes the memory port between stages.

## Interface
Parameters:
- KEY_BYTES, default 3: number of key bytes. The key is 8*KEY_BYTES bits wide.

Ports:
- clk, in, 1: clock, rising-edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: level-sensitive run request, sampled only in IDLE and DONE.
- secret_key, in, 8*KEY_BYTES: the key. Key byte 0 is the most significant byte, byte KEY_BYTES-1 the least significant. Latched on the cycle the block leaves IDLE.
- q, in, 8: S-memory read data. The memory has one cycle of latency: the address is registered at a rising edge and q is valid during the following cycle.
- address, out, 8: S-memory address.
- data, out, 8: S-memory write data.
- wren, out, 1: S-memory write enable.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: high in DONE only.

## Operation
- Internal registers:
  - i, 8 bits, loop index.
  - j, 8 bits, swap index. All j arithmetic wraps modulo 256 (carry discarded).
  - kidx, key byte index, counts 0..KEY_BYTES-1 and wraps to 0. It is a wrapping counter, not a divider.
  - si, sj, 8 bits each: captured memory values.
  - key_q: latched copy of secret_key.
- States and transitions:
  - IDLE:
    - Outputs: address=0, wren=0.
    - If start=1, go to ADDR_I and load i=0, j=0, kidx=0, key_q=secret_key.
  - ADDR_I:
    - Outputs: address=i, wren=0.
    - Always go to READ_I.
  - READ_I:
    - Outputs: address=i, wren=0.
    - Capture si<=q and update j<=j+q+key_q[kidx].
    - Go to ADDR_J.
  - ADDR_J:
    - Outputs: address=j (the updated value), wren=0.
    - Go to READ_J.
  - READ_J:
    - Outputs: address=j, wren=0.
    - Capture sj<=q.
    - Go to WRITE_I.
  - WRITE_I:
    - Outputs: address=i, data=sj, wren=1.
    - Go to WRITE_J.
  - WRITE_J:
    - Outputs: address=j, data=si, wren=1.
    - If i=255, go to DONE.
    - Otherwise increment i<=i+1, advance kidx (wrapping), and go to ADDR_I.
  - DONE:
    - Outputs: done=1, wren=0, address=0.
    - If start=0, go to IDLE. Otherwise hold.
    - A restart therefore needs start to fall and rise again.
- Outputs are Moore-decoded from state and registers. In all non-write states, data=0.
- Boundary conditions:
  - i=j: both writes hit the same address with the same value (si=sj). Memory is unchanged, and no special case is needed.
  - j wraps freely past 255 to 0.
  - Index i never exceeds 255. The loop terminates at i=255; i does not wrap.
  - secret_key changes while busy: ignored, because key_q is used.
  - start toggling while busy: ignored.
  - reset asserted at any time: immediately go to IDLE, clear all registers, and set address=0, data=0, wren=0, busy=0, done=0. S-memory contents are not restored; the init stage must run again.

## Timing
- Reset value of every output is 0.
- Timing origin: start=1 is sampled in IDLE at edge E0.
  - ADDR_I for i=0 occupies cycle 1 (the cycle after E0).
  - Each iteration takes exactly 6 cycles.
  - WRITE_J for i=255 occupies cycle 1536.
  - done=1 from cycle 1537 onward.
- busy=1 during cycles 1..1536.
- Exactly 512 wren-high cycles per run. They arrive in pairs (WRITE_I, WRITE_J) on cycles 6n+5 and 6n+6, for n=0..255.
- In DONE, after start drops: done=0 and the block is in IDLE one cycle later.
- Read-capture rule: q is sampled only in READ_I and READ_J, each one cycle after the corresponding address was first presented.

## Test plan
- Reset:
  - Stimulus: assert reset with random start, key and q.
  - Response: address, data, wren, busy and done all 0. The block stays in IDLE while start=0 after release.
- Zero key, memory preloaded S[i]=i, KEY_BYTES=3, key 0x000000:
  - i=0 gives j=0 with writes (0,0),(0,0).
  - i=1 gives j=1.
  - i=2 gives j=3 with writes addr2=3, then addr3=2.
- Key 0x000249:
  - i=0 gives j=0.
  - i=1 gives j=0+1+0x02=3, with writes addr1=3, then addr3=1.
  - The final 256-entry memory must match the software RC4 KSA model byte-for-byte.
- Cycle accounting:
  - done rises exactly 1537 cycles after E0.
  - wren is high for exactly 512 cycles.
  - Each q capture occurs one cycle after the matching address.
- Reset mid-run:
  - Stimulus: assert reset during iteration 100 WRITE_I.
  - Response: outputs 0 asynchronously, before the next edge.
  - After re-init of memory and a restart with key 0x000249, the final memory matches the model.
- Handshake:
  - Holding start=1 after done keeps the block in DONE with no writes.
  - Dropping start returns it to IDLE with done=0 one cycle later.
  - Raising start again with a new key, after memory re-init, produces that key's permutation.
  - Changing secret_key mid-run has no effect on the result.

Source files
------------

// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm
// RC4 key-scheduling stage. After the S-memory init stage has written S[i]=i,
// this block runs the 256-iteration swap loop
//   j = j + S[i] + key[i mod KEY_BYTES]; swap(S[i], S[j])
// over a shared single-port S-memory with one cycle of read latency.
//
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous, active-low reset
//   start       : level run request, sampled only in IDLE and DONE
//   secret_key  : key, byte 0 in the most significant byte; latched on leaving IDLE
//   q           : S-memory read data (valid the cycle after the address)
//   address     : S-memory address
//   data        : S-memory write data
//   wren        : S-memory write enable
//   busy        : high in every state except IDLE and DONE
//   done        : high in DONE only
module ksa_swap_fsm #(
  parameter int KEY_BYTES = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [8*KEY_BYTES-1:0]   secret_key,
  input  logic [7:0]               q,
  output logic [7:0]               address,
  output logic [7:0]               data,
  output logic                     wren,
  output logic                     busy,
  output logic                     done
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_I,
    S_READ_I,
    S_ADDR_J,
    S_READ_J,
    S_WRITE_I,
    S_WRITE_J,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             key_byte;

  // Key byte 0 sits in the MSBs, so index kidx selects from the top down.
  always_comb begin
    key_byte = '0;
    for (int unsigned k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KW'(k)) begin
        key_byte = key_q[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      key_q   <= key_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    si_d    = si_q;
    sj_d    = sj_q;
    key_d   = key_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR_I;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          key_d   = secret_key;
        end
      end
      S_ADDR_I: state_d = S_READ_I;
      S_READ_I: begin
        // q now holds S[i]; j arithmetic wraps mod 256.
        si_d    = q;
        j_d     = j_q + q + key_byte;
        state_d = S_ADDR_J;
      end
      S_ADDR_J: state_d = S_READ_J;
      S_READ_J: begin
        sj_d    = q;
        state_d = S_WRITE_I;
      end
      S_WRITE_I: state_d = S_WRITE_J;
      S_WRITE_J: begin
        if (i_q == 8'hFF) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KW'(1);
          state_d = S_ADDR_I;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;

    case (state_q)
      S_IDLE:    busy = 1'b0;
      S_ADDR_I:  address = i_q;
      S_READ_I:  address = i_q;
      S_ADDR_J:  address = j_q;
      S_READ_J:  address = j_q;
      S_WRITE_I: begin
        address = i_q;
        data    = sj_q;
        wren    = 1'b1;
      end
      S_WRITE_J: begin
        address = j_q;
        data    = si_q;
        wren    = 1'b1;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Testbench for ksa_swap_fsm: behavioural S-memory with one cycle of read
// latency, software RC4 KSA model feeding a write scoreboard, and a negedge
// monitor that checks writes, per-cycle address sequencing and done timing.
module tb_ksa_swap_fsm;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [23:0] secret_key = '0;
  logic [7:0]  q;
  logic [7:0]  address, data;
  logic        wren, busy, done;

  // Memory model
  logic [7:0] mem [256];
  logic [7:0] addr_r = '0;
  logic       init_req = 1'b0;
  logic       q_rand_en = 1'b0;
  logic [7:0] q_rand = '0;

  // Model / scoreboard state
  wr_t        exp_q [$];
  logic [7:0] exp_mem [256];
  logic [7:0] exp_j [256];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         c1 = 0;
  bit         mon_en = 1'b0;

  // Monitor-owned counters (monotonic; runs use snapshots)
  int         wr_total = 0;
  int         pat_err = 0;
  int         hold_wr = 0;
  int         done_cyc = 0;
  logic       done_prev = 1'b0;
  logic [15:0] cap [6];
  int         m_n, m_ph, m_it, m_idx;
  logic [7:0] m_ea;
  wr_t        m_e;

  ksa_swap_fsm #(.KEY_BYTES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .q          (q),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    addr_r <= address;
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[address] <= data;
    end
  end

  assign q = q_rand_en ? q_rand : mem[addr_r];

  task automatic chk(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Software RC4 KSA: fills exp_mem/exp_j and queues the expected write stream.
  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j, kb, t;
    exp_q.delete();
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j = j + s[i] + kb;
      exp_j[i] = j;
      exp_q.push_back('{a: 8'(i), d: s[j]});
      exp_q.push_back('{a: j, d: s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int k = 0; k < 256; k++) exp_mem[k] = s[k];
  endtask

  always @(negedge clk) begin
    if (reset && mon_en) begin
      m_n = cyc - c1 + 1;
      if (m_n >= 1 && m_n <= 1536) begin
        m_ph = (m_n - 1) % 6;
        m_it = (m_n - 1) / 6;
        m_ea = (m_ph < 2) ? 8'(m_it) : exp_j[m_it];
        if (busy !== 1'b1 || done !== 1'b0 || wren !== (m_ph >= 4) ||
            (m_ph < 4 && (address !== m_ea || data !== 8'h00))) begin
          if (pat_err == 0)
            $display("FAIL seq: cycle %0d addr %0h wren %b busy %b, want addr %0h wren %b busy 1",
                     m_n, address, wren, busy, m_ea, (m_ph >= 4));
          pat_err++;
        end
        if (wren && m_ph >= 4) begin
          m_idx = m_it * 2 + (m_ph - 4);
          if (m_idx < 6) cap[m_idx] = {address, data};
        end
      end else if (m_n > 1536 && wren) begin
        hold_wr++;
      end
      if (wren) begin
        wr_total++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", {16'h0, address, data}, 32'h0);
        end else begin
          m_e = exp_q.pop_front();
          chk(address == m_e.a && data == m_e.d, "write", {16'h0, address, data}, {16'h0, m_e.a, m_e.d});
        end
      end
      if (done && !done_prev) done_cyc = m_n;
    end
    done_prev = done;
  end

  task automatic init_mem();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  task automatic begin_run(input logic [23:0] key);
    build_model(key);
    @(negedge clk);
    #1;
    secret_key = key;
    start = 1'b1;
    c1 = cyc + 1;
    mon_en = 1'b1;
  endtask

  task automatic check_final_mem(input string name);
    int diffs, first;
    diffs = 0;
    first = -1;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_mem[k]) begin
        if (first < 0) first = k;
        diffs++;
      end
    end
    if (first < 0) first = 0;
    chk(diffs == 0, name, {16'h0, 8'(first), mem[first]}, {16'h0, 8'(first), exp_mem[first]});
  endtask

  // Full run: start, wait for done, check accounting and result, hold, release.
  task automatic run_ksa(input logic [23:0] key, input bit change_key);
    int wr0, pe0, hw0, t;
    wr0 = wr_total;
    pe0 = pat_err;
    hw0 = hold_wr;
    begin_run(key);
    t = 0;
    while (!done && t < 1700) begin
      @(negedge clk);
      if (change_key && t == 300) secret_key = ~key;
      t++;
    end
    #1;
    chk(done === 1'b1, "done_timeout", {31'h0, done}, 32'h1);
    chk(done_cyc == 1537, "done_cycle", done_cyc, 1537);
    chk(wr_total - wr0 == 512, "wren_count", wr_total - wr0, 512);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    chk(pat_err == pe0, "seq_errors", pat_err - pe0, 0);
    check_final_mem("final_mem");
    // Hold start high: must stay in DONE, no writes.
    repeat (20) @(negedge clk);
    #1;
    chk(done === 1'b1 && busy === 1'b0, "hold_done", {30'h0, done, busy}, 32'h2);
    chk(hold_wr == hw0, "hold_no_write", hold_wr - hw0, 0);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk(done === 1'b0 && busy === 1'b0, "drop_to_idle", {30'h0, done, busy}, 32'h0);
    mon_en = 1'b0;
  endtask

  logic [15:0] hand_zero [6];
  logic [15:0] hand_249 [4];

  initial begin
    hand_zero = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    hand_249  = '{16'h0000, 16'h0000, 16'h0103, 16'h0301};

    // Reset with random inputs
    q_rand_en = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      start = 1'($urandom);
      secret_key = 24'($urandom);
      q_rand = 8'($urandom);
      #1;
      chk({address, data, wren, busy, done} == '0, "reset_outputs",
          {13'h0, address, data, wren, busy, done}, 32'h0);
    end
    @(negedge clk);
    start = 1'b0;
    q_rand_en = 1'b0;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk({address, data, wren, busy, done} == '0, "idle_after_reset",
        {13'h0, address, data, wren, busy, done}, 32'h0);

    // Zero key
    init_mem();
    run_ksa(24'h000000, 1'b0);
    for (int k = 0; k < 6; k++) chk(cap[k] == hand_zero[k], "hand_zero_write", cap[k], hand_zero[k]);

    // Key 0x000249
    init_mem();
    run_ksa(24'h000249, 1'b0);
    for (int k = 0; k < 4; k++) chk(cap[k] == hand_249[k], "hand_249_write", cap[k], hand_249[k]);

    // Key changed mid-run must not affect the result
    init_mem();
    run_ksa(24'h0A1B2C, 1'b1);

    // Reset during iteration 100 WRITE_I (cycle 605)
    init_mem();
    begin_run(24'h3C5A7E);
    begin
      int t;
      t = 0;
      while ((cyc - c1 + 1) != 605 && t < 700) begin
        @(negedge clk);
        t++;
      end
      chk((cyc - c1 + 1) == 605, "reach_iter100", cyc - c1 + 1, 605);
    end
    #2;
    chk(wren === 1'b1, "iter100_write_i", {31'h0, wren}, 32'h1);
    reset = 1'b0;
    #1;
    chk({address, data, wren, busy, done} == '0, "async_reset_outputs",
        {13'h0, address, data, wren, busy, done}, 32'h0);
    mon_en = 1'b0;
    exp_q.delete();
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    init_mem();
    run_ksa(24'h000249, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
